// File: rtl/wb_write_queue.sv
// wb_write_queue
//   Writer side of the register file. Collects results from the load/store
//   unit (mem_*) and the ALU (alu_*) into a small in-order FIFO. It retires
//   one entry per cycle through a registered output stage that drives the
//   single register-file write port.
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     mem_valid/rd/data/ready   load result handshake (enqueued first when both push)
//     alu_valid/rd/data/ready   ALU result handshake
//     wb_reg_write/register/data  register-file write port (registered)
//     pending_cnt               entries held in the FIFO (output stage excluded)
//     byp_addr1/2, byp_hit1/2, byp_data1/2  youngest-pending-value lookups
//
//   Optional feature macro: WB_BYPASS_EN. When it is undefined, the lookup
//   ports return hit=0 and data=0 and no comparators are built.
module wb_write_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_valid,
   input  logic [ADDR_W-1:0]          mem_rd,
   input  logic [DATA_W-1:0]          mem_data,
   output logic                       mem_ready,
   input  logic                       alu_valid,
   input  logic [ADDR_W-1:0]          alu_rd,
   input  logic [DATA_W-1:0]          alu_data,
   output logic                       alu_ready,
   output logic                       wb_reg_write,
   output logic [ADDR_W-1:0]          wb_write_register,
   output logic [DATA_W-1:0]          wb_write_data,
   output logic [$clog2(DEPTH+1)-1:0] pending_cnt,
   input  logic [ADDR_W-1:0]          byp_addr1,
   output logic                       byp_hit1,
   output logic [DATA_W-1:0]          byp_data1,
   input  logic [ADDR_W-1:0]          byp_addr2,
   output logic                       byp_hit2,
   output logic [DATA_W-1:0]          byp_data2
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
   logic [ADDR_W-1:0] fifo_rd_d   [DEPTH];
   logic [DATA_W-1:0] fifo_data_q [DEPTH];
   logic [DATA_W-1:0] fifo_data_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_mid;
   logic [CW-1:0]     count_q, count_d;
   logic              wb_vld_q, wb_vld_d;
   logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              mem_push, alu_push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // Readiness looks only at the registered count, so a same-cycle pop never
   // opens a slot. alu_ready reserves room for a concurrent mem transfer.
   assign mem_ready = ({1'b0, count_q} < (CW+1)'(DEPTH));
   assign alu_ready = (({1'b0, count_q} + {{CW{1'b0}}, mem_valid}) < (CW+1)'(DEPTH));

   // An r0 transfer completes the handshake but never occupies a slot.
   assign mem_push = mem_valid && mem_ready && (mem_rd != '0);
   assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
   assign pop      = (count_q != '0);

   always_comb begin
      fifo_rd_d   = fifo_rd_q;
      fifo_data_d = fifo_data_q;
      wb_vld_d    = pop;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_mid  = wr_ptr_q;
      // mem goes into the older slot, alu into the one after it
      if (mem_push) begin
         fifo_rd_d[wr_ptr_q]   = mem_rd;
         fifo_data_d[wr_ptr_q] = mem_data;
         wr_ptr_mid            = ptr_inc(wr_ptr_q);
      end
      wr_ptr_d = wr_ptr_mid;
      if (alu_push) begin
         fifo_rd_d[wr_ptr_mid]   = alu_rd;
         fifo_data_d[wr_ptr_mid] = alu_data;
         wr_ptr_d                = ptr_inc(wr_ptr_mid);
      end
      if (pop) begin
         wb_rd_d   = fifo_rd_q[rd_ptr_q];
         wb_data_d = fifo_data_q[rd_ptr_q];
         rd_ptr_d  = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_rd_q[i]   <= '0;
            fifo_data_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wb_vld_q  <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         fifo_rd_q   <= fifo_rd_d;
         fifo_data_q <= fifo_data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wb_vld_q    <= wb_vld_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
      end
   end

   assign wb_reg_write      = wb_vld_q;
   assign wb_write_register = wb_rd_q;
   assign wb_write_data     = wb_data_q;
   assign pending_cnt       = count_q;

`ifdef WB_BYPASS_EN
   logic [PW:0] idx_w;
   logic [PW-1:0] idx;

   // Scan the output stage first (oldest), then FIFO entries from head to
   // tail. A later match overrides an earlier one, so the youngest wins.
   always_comb begin
      idx_w     = '0;
      idx       = '0;
      byp_hit1  = wb_vld_q && (wb_rd_q == byp_addr1);
      byp_data1 = wb_data_q;
      byp_hit2  = wb_vld_q && (wb_rd_q == byp_addr2);
      byp_data2 = wb_data_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx_w = {1'b0, rd_ptr_q} + (PW+1)'(i);
         if (idx_w >= (PW+1)'(DEPTH)) idx_w = idx_w - (PW+1)'(DEPTH);
         idx = idx_w[PW-1:0];
         if (CW'(i) < count_q) begin
            if (fifo_rd_q[idx] == byp_addr1) begin
               byp_hit1  = 1'b1;
               byp_data1 = fifo_data_q[idx];
            end
            if (fifo_rd_q[idx] == byp_addr2) begin
               byp_hit2  = 1'b1;
               byp_data2 = fifo_data_q[idx];
            end
         end
      end
      if (!byp_hit1 || byp_addr1 == '0) begin
         byp_hit1  = 1'b0;
         byp_data1 = '0;
      end
      if (!byp_hit2 || byp_addr2 == '0) begin
         byp_hit2  = 1'b0;
         byp_data2 = '0;
      end
   end
`else
   logic unused_byp;
   assign unused_byp = ^{byp_addr1, byp_addr2};
   assign byp_hit1   = 1'b0;
   assign byp_data1  = '0;
   assign byp_hit2   = 1'b0;
   assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue (DEPTH=4). A negedge monitor checks each
// write-port strobe against an expected in-order list built by the stimulus.
module tb_wb_write_queue;
   localparam int DEPTH = 4, DATA_W = 32, ADDR_W = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic mem_valid, alu_valid, mem_ready, alu_ready;
   logic [ADDR_W-1:0] mem_rd, alu_rd, wb_write_register, byp_addr1, byp_addr2;
   logic [DATA_W-1:0] mem_data, alu_data, wb_write_data, byp_data1, byp_data2;
   logic wb_reg_write, byp_hit1, byp_hit2;
   logic [$clog2(DEPTH+1)-1:0] pending_cnt;

   wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register),
      .wb_write_data(wb_write_data), .pending_cnt(pending_cnt),
      .byp_addr1(byp_addr1), .byp_hit1(byp_hit1), .byp_data1(byp_data1),
      .byp_addr2(byp_addr2), .byp_hit2(byp_hit2), .byp_data2(byp_data2)
   );

   int errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct packed { logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] d; } wr_t;
   wr_t exp_q[$];
   wr_t mon_e;

   always @(negedge clk) begin
      if (wb_reg_write === 1'b1) begin
         if (exp_q.size() == 0) chk("wb_extra", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk("wb_rd", wb_write_register, mon_e.rd);
            chk("wb_data", wb_write_data, mon_e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic set_mem(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
      mem_valid = v; mem_rd = rd; mem_data = d;
   endtask
   task automatic set_alu(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
      alu_valid = v; alu_rd = rd; alu_data = d;
   endtask

   initial begin
      rst = 1'b1;
      set_mem(0, 0, 0); set_alu(0, 0, 0);
      byp_addr1 = '0; byp_addr2 = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_wb", wb_reg_write, 0);
      chk("rst_reg", wb_write_register, 0);
      chk("rst_data", wb_write_data, 0);
      chk("rst_cnt", pending_cnt, 0);
      chk("rst_mrdy", mem_ready, 1);
      chk("rst_ardy", alu_ready, 1);
      chk("rst_hit1", byp_hit1, 0);
      rst = 1'b0;

      // single write
      set_alu(1, 5'd3, 32'h1234);
      exp_q.push_back('{5'd3, 32'h1234});
      #1 chk("t1_ardy", alu_ready, 1);
      @(negedge clk);
      set_alu(0, 0, 0);
      chk("t1_cnt1", pending_cnt, 1);
      chk("t1_wb_early", wb_reg_write, 0);
      @(negedge clk);
      chk("t1_wb", wb_reg_write, 1);
      chk("t1_reg", wb_write_register, 3);
      chk("t1_data", wb_write_data, 32'h1234);
      chk("t1_cnt0", pending_cnt, 0);
      @(negedge clk);
      chk("t1_wb_off", wb_reg_write, 0);
      chk("t1_hold_reg", wb_write_register, 3);
      chk("t1_hold_data", wb_write_data, 32'h1234);

      // dual push: mem older than alu
      set_mem(1, 5'd5, 32'hAAAA); set_alu(1, 5'd6, 32'hBBBB);
      exp_q.push_back('{5'd5, 32'hAAAA}); exp_q.push_back('{5'd6, 32'hBBBB});
      #1 chk("t2_mrdy", mem_ready, 1); chk("t2_ardy", alu_ready, 1);
      @(negedge clk);
      set_mem(0, 0, 0); set_alu(0, 0, 0);
      chk("t2_cnt2", pending_cnt, 2);
      @(negedge clk);
      chk("t2_first", wb_write_register, 5);
      chk("t2_cnt1", pending_cnt, 1);
      @(negedge clk);
      chk("t2_second", wb_write_register, 6);
      chk("t2_cnt0", pending_cnt, 0);
      @(negedge clk);
      chk("t2_idle", wb_reg_write, 0);
      chk("t2_sb", exp_q.size(), 0);

      // fill / backpressure: alu stalls once count reaches 3 with mem valid
      foreach (exp_q[i]) exp_q.delete(i);
      exp_q.push_back('{5'd1, 32'h11}); exp_q.push_back('{5'd2, 32'h22});
      exp_q.push_back('{5'd3, 32'h33}); exp_q.push_back('{5'd4, 32'h44});
      exp_q.push_back('{5'd5, 32'h55}); exp_q.push_back('{5'd7, 32'h77});
      exp_q.push_back('{5'd6, 32'h66});
      set_mem(1, 5'd1, 32'h11); set_alu(1, 5'd2, 32'h22);
      #1 chk("t3_ardy0", alu_ready, 1);
      @(negedge clk);
      chk("t3_cnt_a", pending_cnt, 2);
      set_mem(1, 5'd3, 32'h33); set_alu(1, 5'd4, 32'h44);
      #1 chk("t3_ardy2", alu_ready, 1);
      @(negedge clk);
      chk("t3_cnt_b", pending_cnt, 3);
      set_mem(1, 5'd5, 32'h55); set_alu(1, 5'd6, 32'h66);
      #1 chk("t3_mrdy3", mem_ready, 1); chk("t3_ardy3", alu_ready, 0);
      @(negedge clk);
      chk("t3_cnt_c", pending_cnt, 3);
      set_mem(1, 5'd7, 32'h77);
      #1 chk("t3_ardy3b", alu_ready, 0);
      @(negedge clk);
      chk("t3_cnt_d", pending_cnt, 3);
      set_mem(0, 0, 0);
      #1 chk("t3_ardy_free", alu_ready, 1); chk("t3_mrdy_free", mem_ready, 1);
      @(negedge clk);
      chk("t3_cnt_e", pending_cnt, 3);
      set_alu(0, 0, 0);
      repeat (4) @(negedge clk);
      chk("t3_cnt_end", pending_cnt, 0);
      chk("t3_sb", exp_q.size(), 0);

      // r0 write: handshake completes, nothing stored
      set_alu(1, 5'd0, 32'hDEAD);
      #1 chk("t4_ardy", alu_ready, 1);
      @(negedge clk);
      set_alu(0, 0, 0);
      chk("t4_cnt", pending_cnt, 0);
      @(negedge clk);
      chk("t4_wb", wb_reg_write, 0);

      // bypass lookups
      set_mem(1, 5'd7, 32'h1); set_alu(1, 5'd7, 32'h2);
      exp_q.push_back('{5'd7, 32'h1}); exp_q.push_back('{5'd7, 32'h2});
      @(negedge clk);
      set_mem(0, 0, 0); set_alu(0, 0, 0);
      byp_addr1 = 5'd7; byp_addr2 = 5'd0;
      #1;
`ifdef WB_BYPASS_EN
      chk("t5_hit1", byp_hit1, 1); chk("t5_data1", byp_data1, 2);
`else
      chk("t5_hit1", byp_hit1, 0); chk("t5_data1", byp_data1, 0);
`endif
      chk("t5_hit2_r0", byp_hit2, 0);
      @(negedge clk);
      byp_addr2 = 5'd7;
      #1;
`ifdef WB_BYPASS_EN
      chk("t5_mix_hit2", byp_hit2, 1); chk("t5_mix_data2", byp_data2, 2);
`else
      chk("t5_mix_hit2", byp_hit2, 0); chk("t5_mix_data2", byp_data2, 0);
`endif
      @(negedge clk);
      #1;
`ifdef WB_BYPASS_EN
      chk("t5_out_hit1", byp_hit1, 1); chk("t5_out_data1", byp_data1, 2);
`else
      chk("t5_out_hit1", byp_hit1, 0); chk("t5_out_data1", byp_data1, 0);
`endif
      @(negedge clk);
      #1 chk("t5_gone", byp_hit1, 0);
      byp_addr1 = '0; byp_addr2 = '0;

      // reset mid-drain with three entries pending
      set_mem(1, 5'd8, 32'h88); set_alu(1, 5'd9, 32'h99);
      exp_q.push_back('{5'd8, 32'h88});
      @(negedge clk);
      set_mem(1, 5'd10, 32'hA0); set_alu(1, 5'd11, 32'hB0);
      @(negedge clk);
      set_mem(0, 0, 0); set_alu(0, 0, 0);
      chk("t6_cnt3", pending_cnt, 3);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_wb", wb_reg_write, 0);
      chk("t6_cnt", pending_cnt, 0);
      chk("t6_mrdy", mem_ready, 1);
      chk("t6_ardy", alu_ready, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_wb_after", wb_reg_write, 0);
      chk("t6_sb", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
